// File: rtl/core_pipe_wb.sv
// Writeback stage: single-entry holding register feeding the register file write port.
// Loads wait here for their data-bus response, then get aligned and extended.
module core_pipe_wb #(
   parameter int unsigned XL         = 63,
   parameter int unsigned REG_ADDR_R = 4
) (
   input  logic                  g_clk,
   input  logic                  g_resetn,

   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic                  s_wen,
   input  logic [REG_ADDR_R:0]   s_rd,
   input  logic [XL:0]           s_wdata,
   input  logic                  s_load,
   input  logic [1:0]            s_ld_size,
   input  logic                  s_ld_sext,
   input  logic [2:0]            s_ld_off,

   input  logic                  dmem_rsp_valid,
   output logic                  dmem_rsp_ready,
   input  logic [63:0]           dmem_rsp_rdata,
   input  logic                  dmem_rsp_error,

   output logic                  rd_wen,
   output logic [REG_ADDR_R:0]   rd_addr,
   output logic [XL:0]           rd_wdata,

   output logic                  wb_retire,
   output logic                  wb_trap,
   output logic                  hz_valid,
   output logic [REG_ADDR_R:0]   hz_rd
);

   typedef enum logic [1:0] {StEmpty, StHold, StWait} state_e;

   state_e              state_q, state_d;
   logic                wen_q;
   logic [REG_ADDR_R:0] rd_q;
   logic [XL:0]         wdata_q;
   logic [1:0]          size_q;
   logic                sext_q;
   logic [2:0]          off_q;

   logic                accept;
   logic                rd_nonzero;
   logic [63:0]         shifted;
   logic [63:0]         ld_ext;

   // The held entry drains in the same cycle a new one is captured.
   assign s_ready    = (state_q != StWait) || dmem_rsp_valid;
   assign accept     = s_valid && s_ready;
   assign rd_nonzero = (rd_q != '0);

   assign hz_valid = (state_q == StWait);
   assign hz_rd    = rd_q;
   assign rd_addr  = rd_q;

   always_comb begin
      shifted = dmem_rsp_rdata >> {off_q, 3'b000};
      ld_ext  = shifted;
      unique case (size_q)
         2'b00:   ld_ext = {{56{sext_q & shifted[7]}},  shifted[7:0]};
         2'b01:   ld_ext = {{48{sext_q & shifted[15]}}, shifted[15:0]};
         2'b10:   ld_ext = {{32{sext_q & shifted[31]}}, shifted[31:0]};
         default: ld_ext = shifted;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      rd_wen         = 1'b0;
      rd_wdata       = wdata_q;
      wb_retire      = 1'b0;
      wb_trap        = 1'b0;
      dmem_rsp_ready = 1'b0;
      unique case (state_q)
         StHold: begin
            rd_wen    = wen_q && rd_nonzero;
            wb_retire = 1'b1;
            state_d   = StEmpty;
         end
         StWait: begin
            dmem_rsp_ready = 1'b1;
            rd_wdata       = ld_ext[XL:0];
            if (dmem_rsp_valid) begin
               rd_wen    = wen_q && rd_nonzero && !dmem_rsp_error;
               wb_trap   = dmem_rsp_error;
               wb_retire = 1'b1;
               state_d   = StEmpty;
            end
         end
         default: ;
      endcase
      if (accept) begin
         state_d = s_load ? StWait : StHold;
      end
   end

   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         state_q <= StEmpty;
         wen_q   <= 1'b0;
         rd_q    <= '0;
         wdata_q <= '0;
         size_q  <= 2'b00;
         sext_q  <= 1'b0;
         off_q   <= 3'b000;
      end else begin
         state_q <= state_d;
         if (accept) begin
            wen_q   <= s_wen;
            rd_q    <= s_rd;
            wdata_q <= s_wdata;
            size_q  <= s_ld_size;
            sext_q  <= s_ld_sext;
            off_q   <= s_ld_off;
         end
      end
   end

endmodule

// File: tb/tb_core_pipe_wb.sv
// Scoreboard bench for core_pipe_wb: expected writebacks are queued at issue and
// popped when the stage retires an instruction.
module tb_core_pipe_wb;

   logic        g_clk;
   logic        g_resetn;
   logic        s_valid, s_ready, s_wen, s_load, s_ld_sext;
   logic [4:0]  s_rd;
   logic [63:0] s_wdata;
   logic [1:0]  s_ld_size;
   logic [2:0]  s_ld_off;
   logic        dmem_rsp_valid, dmem_rsp_ready, dmem_rsp_error;
   logic [63:0] dmem_rsp_rdata;
   logic        rd_wen, wb_retire, wb_trap, hz_valid;
   logic [4:0]  rd_addr, hz_rd;
   logic [63:0] rd_wdata;

   typedef struct packed {
      logic        wen;
      logic [4:0]  rd;
      logic [63:0] data;
      logic        trap;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_tests = 0;
   int   n_fail  = 0;

   core_pipe_wb dut (
      .g_clk          (g_clk),
      .g_resetn       (g_resetn),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .s_wen          (s_wen),
      .s_rd           (s_rd),
      .s_wdata        (s_wdata),
      .s_load         (s_load),
      .s_ld_size      (s_ld_size),
      .s_ld_sext      (s_ld_sext),
      .s_ld_off       (s_ld_off),
      .dmem_rsp_valid (dmem_rsp_valid),
      .dmem_rsp_ready (dmem_rsp_ready),
      .dmem_rsp_rdata (dmem_rsp_rdata),
      .dmem_rsp_error (dmem_rsp_error),
      .rd_wen         (rd_wen),
      .rd_addr        (rd_addr),
      .rd_wdata       (rd_wdata),
      .wb_retire      (wb_retire),
      .wb_trap        (wb_trap),
      .hz_valid       (hz_valid),
      .hz_rd          (hz_rd)
   );

   initial g_clk = 1'b0;
   always #5 g_clk = ~g_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "timeout");
   end

   function automatic exp_t mk(logic wen, logic [4:0] rd, logic [63:0] data, logic trap);
      exp_t x;
      x.wen  = wen && (rd != 5'd0) && !trap;
      x.rd   = rd;
      x.data = data;
      x.trap = trap;
      return x;
   endfunction

   // Byte-wise reference for load alignment and extension.
   function automatic logic [63:0] ld_model(logic [63:0] w, int sz, int off, bit sx);
      int          nb;
      logic [63:0] r;
      nb = 1 << sz;
      r  = '0;
      for (int i = 0; i < 8; i++)
         if (i < nb) r[8*i +: 8] = w[8*(off+i) +: 8];
      if (sx && r[8*nb-1])
         for (int i = 0; i < 64; i++)
            if (i >= 8*nb) r[i] = 1'b1;
      return r;
   endfunction

   task automatic idle_inputs();
      s_valid = 0; s_wen = 0; s_rd = 0; s_wdata = 0; s_load = 0;
      s_ld_size = 0; s_ld_sext = 0; s_ld_off = 0;
      dmem_rsp_valid = 0; dmem_rsp_rdata = 0; dmem_rsp_error = 0;
   endtask

   task automatic drive_instr(logic load, logic wen, logic [4:0] rd, logic [63:0] wd,
                              logic [1:0] sz, logic sx, logic [2:0] off);
      s_valid = 1; s_load = load; s_wen = wen; s_rd = rd; s_wdata = wd;
      s_ld_size = sz; s_ld_sext = sx; s_ld_off = off;
   endtask

   task automatic test_reset();
      g_resetn = 0;
      idle_inputs();
      repeat (2) @(posedge g_clk);
      @(negedge g_clk);
      n_tests++;
      if ({s_ready, rd_wen, wb_retire, wb_trap, hz_valid, dmem_rsp_ready} !== 6'b100000) begin
         n_fail++;
         $display("FAIL reset_outputs: got ready/wen/ret/trap/hz/rsprdy=%b want 100000",
                  {s_ready, rd_wen, wb_retire, wb_trap, hz_valid, dmem_rsp_ready});
      end
      @(posedge g_clk); #1;
      g_resetn = 1;
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 4; c++) begin
         @(posedge g_clk); #1;
         idle_inputs();
         if (c == 0) begin drive_instr(0, 1, 5'd5, 64'h11, 0, 0, 0); sb.push_back(mk(1, 5, 64'h11, 0)); end
         if (c == 1) begin drive_instr(0, 1, 5'd6, 64'h22, 0, 0, 0); sb.push_back(mk(1, 6, 64'h22, 0)); end
         if (c == 2) begin drive_instr(0, 1, 5'd5, 64'h33, 0, 0, 0); sb.push_back(mk(1, 5, 64'h33, 0)); end
         @(negedge g_clk);
         n_tests++;
         if (s_ready !== 1'b1 || wb_retire !== (c > 0)) begin
            n_fail++;
            $display("FAIL b2b_flow c=%0d: got ready=%b retire=%b want ready=1 retire=%b",
                     c, s_ready, wb_retire, c > 0);
         end
         if (c > 0 && wb_retire === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if ({rd_wen, rd_addr, rd_wdata, wb_trap} !== {e.wen, e.rd, e.data, e.trap}) begin
               n_fail++;
               $display("FAIL b2b_write c=%0d: got wen=%b rd=%0d data=%h trap=%b want wen=%b rd=%0d data=%h trap=%b",
                        c, rd_wen, rd_addr, rd_wdata, wb_trap, e.wen, e.rd, e.data, e.trap);
            end
         end
      end
   endtask

   task automatic test_load_byte();
      @(posedge g_clk); #1;
      idle_inputs();
      drive_instr(1, 1, 5'd8, 64'h0, 2'b00, 1, 3'd3);
      sb.push_back(mk(1, 8, 64'hFFFF_FFFF_FFFF_FF80, 0));
      @(negedge g_clk);
      for (int c = 0; c < 2; c++) begin
         @(posedge g_clk); #1;
         idle_inputs();
         // Second load is accepted in the same cycle the first one's response lands.
         if (c == 0) begin
            drive_instr(1, 1, 5'd9, 64'h0, 2'b00, 0, 3'd3);
            sb.push_back(mk(1, 9, 64'h80, 0));
         end
         dmem_rsp_valid = 1;
         dmem_rsp_rdata = 64'h0000_0000_8000_0000;
         @(negedge g_clk);
         n_tests++;
         if (!wb_retire || !dmem_rsp_ready || !s_ready || sb.size() == 0) begin
            n_fail++;
            $display("FAIL ldb_flow c=%0d: got retire=%b rsp_ready=%b s_ready=%b want 1 1 1",
                     c, wb_retire, dmem_rsp_ready, s_ready);
         end else begin
            e = sb.pop_front();
            n_tests++;
            if ({rd_wen, rd_addr, rd_wdata, wb_trap} !== {e.wen, e.rd, e.data, e.trap}) begin
               n_fail++;
               $display("FAIL ldb_write c=%0d: got wen=%b rd=%0d data=%h trap=%b want wen=%b rd=%0d data=%h trap=%b",
                        c, rd_wen, rd_addr, rd_wdata, wb_trap, e.wen, e.rd, e.data, e.trap);
            end
         end
      end
   endtask

   task automatic test_load_late();
      @(posedge g_clk); #1;
      idle_inputs();
      drive_instr(1, 1, 5'd11, 64'h0, 2'b10, 0, 3'd4);
      sb.push_back(mk(1, 11, 64'h1234_5678, 0));
      @(negedge g_clk);
      for (int c = 0; c < 3; c++) begin
         @(posedge g_clk); #1;
         idle_inputs();
         drive_instr(0, 1, 5'd12, 64'h55, 0, 0, 0);
         @(negedge g_clk);
         n_tests++;
         if ({s_ready, hz_valid, hz_rd, wb_retire, rd_wen} !== {1'b0, 1'b1, 5'd11, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL late_stall c=%0d: got ready=%b hz=%b hz_rd=%0d retire=%b wen=%b want 0 1 11 0 0",
                     c, s_ready, hz_valid, hz_rd, wb_retire, rd_wen);
         end
      end
      for (int c = 0; c < 2; c++) begin
         @(posedge g_clk); #1;
         idle_inputs();
         if (c == 0) begin
            drive_instr(0, 1, 5'd12, 64'h55, 0, 0, 0);
            sb.push_back(mk(1, 12, 64'h55, 0));
            dmem_rsp_valid = 1;
            dmem_rsp_rdata = 64'h1234_5678_9ABC_DEF0;
         end
         @(negedge g_clk);
         n_tests++;
         if (!wb_retire || sb.size() == 0) begin
            n_fail++;
            $display("FAIL late_retire c=%0d: got retire=%b want 1", c, wb_retire);
         end else begin
            e = sb.pop_front();
            n_tests++;
            if ({rd_wen, rd_addr, rd_wdata, wb_trap} !== {e.wen, e.rd, e.data, e.trap}) begin
               n_fail++;
               $display("FAIL late_write c=%0d: got wen=%b rd=%0d data=%h trap=%b want wen=%b rd=%0d data=%h trap=%b",
                        c, rd_wen, rd_addr, rd_wdata, wb_trap, e.wen, e.rd, e.data, e.trap);
            end
         end
      end
   endtask

   task automatic test_bus_error();
      @(posedge g_clk); #1;
      idle_inputs();
      drive_instr(1, 1, 5'd7, 64'h0, 2'b11, 1, 3'd0);
      sb.push_back(mk(1, 7, 64'h0, 1));
      @(negedge g_clk);
      @(posedge g_clk); #1;
      idle_inputs();
      dmem_rsp_valid = 1;
      dmem_rsp_error = 1;
      dmem_rsp_rdata = 64'hFFFF_0000_FFFF_0000;
      @(negedge g_clk);
      n_tests++;
      if (!wb_retire || sb.size() == 0) begin
         n_fail++;
         $display("FAIL err_retire: got retire=%b want 1", wb_retire);
      end else begin
         e = sb.pop_front();
         n_tests++;
         if ({rd_wen, rd_addr, wb_trap} !== {e.wen, e.rd, e.trap}) begin
            n_fail++;
            $display("FAIL err_trap: got wen=%b rd=%0d trap=%b want wen=%b rd=%0d trap=%b",
                     rd_wen, rd_addr, wb_trap, e.wen, e.rd, e.trap);
         end
      end
   endtask

   task automatic test_x0();
      @(posedge g_clk); #1;
      idle_inputs();
      drive_instr(0, 1, 5'd0, 64'hDEAD, 0, 0, 0);
      sb.push_back(mk(1, 0, 64'hDEAD, 0));
      @(negedge g_clk);
      @(posedge g_clk); #1;
      idle_inputs();
      @(negedge g_clk);
      n_tests++;
      if (!wb_retire || sb.size() == 0) begin
         n_fail++;
         $display("FAIL x0_retire: got retire=%b want 1", wb_retire);
      end else begin
         e = sb.pop_front();
         n_tests++;
         if ({rd_wen, rd_addr, rd_wdata, wb_trap} !== {e.wen, e.rd, e.data, e.trap}) begin
            n_fail++;
            $display("FAIL x0_write: got wen=%b rd=%0d data=%h trap=%b want wen=%b rd=%0d data=%h trap=%b",
                     rd_wen, rd_addr, rd_wdata, wb_trap, e.wen, e.rd, e.data, e.trap);
         end
      end
   endtask

   task automatic test_load_sizes();
      int          sz, off;
      bit          sx;
      logic [4:0]  rd;
      logic [63:0] w;
      for (int i = 0; i < 12; i++) begin
         sz  = $urandom_range(0, 3);
         off = ($urandom_range(0, 7) >> sz) << sz;
         sx  = 1'($urandom_range(0, 1));
         rd  = 5'($urandom_range(1, 31));
         w   = {$urandom, $urandom};
         @(posedge g_clk); #1;
         idle_inputs();
         drive_instr(1, 1, rd, 64'h0, 2'(sz), sx, 3'(off));
         sb.push_back(mk(1, rd, ld_model(w, sz, off, sx), 0));
         @(negedge g_clk);
         @(posedge g_clk); #1;
         idle_inputs();
         dmem_rsp_valid = 1;
         dmem_rsp_rdata = w;
         @(negedge g_clk);
         n_tests++;
         if (!wb_retire || sb.size() == 0) begin
            n_fail++;
            $display("FAIL sizes_retire i=%0d: got retire=%b want 1", i, wb_retire);
         end else begin
            e = sb.pop_front();
            if ({rd_wen, rd_addr, rd_wdata, wb_trap} !== {e.wen, e.rd, e.data, e.trap}) begin
               n_fail++;
               $display("FAIL sizes_write i=%0d sz=%0d off=%0d sx=%0d: got data=%h wen=%b rd=%0d want data=%h wen=%b rd=%0d",
                        i, sz, off, sx, rd_wdata, rd_wen, rd_addr, e.data, e.wen, e.rd);
            end
         end
      end
   endtask

   task automatic test_reset_in_wait();
      @(posedge g_clk); #1;
      idle_inputs();
      drive_instr(1, 1, 5'd10, 64'h0, 2'b11, 0, 3'd0);
      @(negedge g_clk);
      @(posedge g_clk); #1;
      idle_inputs();
      @(negedge g_clk);
      n_tests++;
      if (hz_valid !== 1'b1 || hz_rd !== 5'd10) begin
         n_fail++;
         $display("FAIL rstwait_hz: got hz=%b hz_rd=%0d want 1 10", hz_valid, hz_rd);
      end
      @(posedge g_clk); #1;
      g_resetn = 0;
      @(posedge g_clk); #1;
      g_resetn = 1;
      dmem_rsp_valid = 1;
      dmem_rsp_rdata = 64'hCAFE;
      @(negedge g_clk);
      n_tests++;
      if ({rd_wen, wb_retire, wb_trap, dmem_rsp_ready, s_ready, hz_valid} !== 6'b000010) begin
         n_fail++;
         $display("FAIL rstwait_abandon: got wen/ret/trap/rsprdy/ready/hz=%b want 000010",
                  {rd_wen, wb_retire, wb_trap, dmem_rsp_ready, s_ready, hz_valid});
      end
      @(posedge g_clk); #1;
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      g_resetn = 0;
      test_reset();
      test_back_to_back();
      test_load_byte();
      test_load_late();
      test_bus_error();
      test_x0();
      test_load_sizes();
      test_reset_in_wait();
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending entries want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
